// File: rtl/pipe5_fetch2_execute_reg_pkg.sv
// Shared types for the fetch2-to-execute link of the 5-stage pipeline:
// payload record, buffer occupancy states and the canonical RV32I NOP.
package pipe5_fetch2_execute_reg_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t pc4;
    word_t instr;
    word_t prediction;
  } f2ex_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } f2ex_state_t;

  // addi x0, x0, 0
  localparam word_t RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe5_fetch2_execute_reg.sv
// Execute-side register of the fetch2->execute link: main entry plus an
// optional skid entry, registered back-pressure, flush and a stall counter.
module pipe5_fetch2_execute_reg
  import pipe5_fetch2_execute_reg_pkg::*;
#(
  parameter bit    SKID_EN   = 1'b1,
  parameter word_t NOP_INSTR = RV_NOP,
  parameter int    CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             f2_token,
  input  logic [31:0]      f2_pc,
  input  logic [31:0]      f2_pc4,
  input  logic [31:0]      f2_instr,
  input  logic [31:0]      f2_prediction,
  output logic             f2_ready,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_pc4,
  output logic [31:0]      ex_instr,
  output logic [31:0]      ex_prediction,
  output logic [CNT_W-1:0] bp_count
);

  f2ex_state_t      state_p0;
  f2ex_payload_t    main_p0;
  f2ex_payload_t    skid_p0;
  logic             ready_p0;
  logic [CNT_W-1:0] bp_count_p0;

  f2ex_payload_t    f2_payload;
  logic             vld_p0;
  logic             accept;
  logic             consume;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign f2_payload = {f2_pc, f2_pc4, f2_instr, f2_prediction};
  assign vld_p0     = (state_p0 != EMPTY);

  // Without the skid entry, readiness must see this cycle's stall directly.
  assign f2_ready = SKID_EN ? ready_p0 : (~vld_p0 | ~ex_stall);
  assign accept   = f2_token & f2_ready;
  assign consume  = vld_p0 & ~ex_stall;

  // ---- stage register: occupancy, main/skid entries, registered ready ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_p0 <= EMPTY;
      main_p0  <= '0;
      skid_p0  <= '0;
      ready_p0 <= 1'b1;
    end else if (flush) begin
      state_p0 <= EMPTY;
      ready_p0 <= 1'b1;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (accept) begin
            main_p0  <= f2_payload;
            state_p0 <= ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_p0 <= f2_payload;
          end else if (accept) begin
            if (SKID_EN) begin
              skid_p0  <= f2_payload;
              state_p0 <= FULL;
              ready_p0 <= 1'b0;
            end else begin
              main_p0 <= f2_payload;
            end
          end else if (consume) begin
            state_p0 <= EMPTY;
          end
        end
        FULL: begin
          // Skid drains into main so ordering stays strictly FIFO.
          if (consume) begin
            main_p0  <= skid_p0;
            state_p0 <= ONE;
            ready_p0 <= 1'b1;
          end
        end
        default: begin
          state_p0 <= EMPTY;
          ready_p0 <= 1'b1;
        end
      endcase
    end
  end

  // ---- back-pressure statistics (survives flush) ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bp_count_p0 <= '0;
    end else if (f2_token && !f2_ready) begin
      bp_count_p0 <= sat_inc(bp_count_p0);
    end
  end

  // ---- execute-side outputs ----
  assign ex_valid      = vld_p0;
  assign ex_pc         = main_p0.pc;
  assign ex_pc4        = main_p0.pc4;
  assign ex_instr      = vld_p0 ? main_p0.instr : NOP_INSTR;
  assign ex_prediction = main_p0.prediction;
  assign bp_count      = bp_count_p0;

endmodule
